board_ctrl: RTL
===============

# board_ctrl

Move sequencer for the 16-cell, 4-bit sliding-puzzle board memory. It owns the memory's address, write-data and write-enable. It initializes the board to the solved layout, executes one blank-tile move per accepted command as a read/write/write sequence, and rescans the board after every move to report the solved status. It sits between the user-input decoder and the board memory.

## Interface
- CNT_W, default 10: width of the move counter.
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- init_req  in  1  request to re-initialize the board; sampled only in IDLE.
- move_valid  in  1  move command valid.
- move_dir  in  2  direction the blank moves: 00 up (−4), 01 down (+4), 10 left (−1), 11 right (+1).
- move_ready  out  1  high only in IDLE while init_req is low.
- done  out  1  one-cycle pulse when an init or legal move completes.
- illegal  out  1  one-cycle pulse when a move is rejected.
- solved  out  1  level; board equals the solved layout.
- blank_pos  out  4  cell index of the blank (value 0).
- move_count  out  CNT_W  legal moves since the last init; saturating.
- mem_addr  out  4  board address; connects to the memory addr[3:0].
- mem_wdata  out  4  board write data.
- mem_we  out  1  board write enable.
- mem_rdata  in  4  board read data, combinational from mem_addr.

## Operation
- Cell index is row*4 + col. Solved layout: cell i holds i+1 for i = 0..14, and cell 15 holds 0.
- States: BOOT, INIT, IDLE, ILL, RD, WR_B, WR_N, SCAN, DONE.
- The mem_* outputs are decoded combinationally from the state and a 4-bit index register. mem_we = 0 in every state except INIT, WR_B and WR_N.
- **BOOT:** reset state. It moves to INIT on the next edge unconditionally.
- **INIT:** runs 16 cycles with idx = 0..15.
  - mem_addr = idx, mem_we = 1.
  - mem_wdata = idx+1 for idx < 15, and 0 for idx = 15.
  - After idx 15: blank_pos ← 15, move_count ← 0, solved ← 1, then go to DONE.
- **IDLE:**
  - If init_req = 1, go to INIT. Init has priority and any move_valid in that cycle is not accepted.
  - Otherwise a move is accepted when move_valid && move_ready. The neighbour n = blank_pos + offset is latched.
- **Legality:** a move is illegal when up with row 0, down with row 3, left with col 0, or right with col 3.
  - An illegal move goes to ILL: illegal = 1 for one cycle, then IDLE.
  - An illegal move makes no memory access and changes neither counters nor blank_pos.
- **Legal move sequence:**
  - RD: mem_addr = n; latch mem_rdata into the tile register.
  - WR_B: mem_addr = blank_pos, mem_wdata = tile, mem_we = 1.
  - WR_N: mem_addr = n, mem_wdata = 0, mem_we = 1. Also blank_pos ← n, and move_count ← move_count + 1, saturating at 2^CNT_W − 1.
  - SCAN: 16 cycles with idx = 0..15 and mem_addr = idx. Each cell is compared against the solved layout and mismatches are accumulated. At idx 15, solved ← (no mismatch).
  - DONE: done = 1 for one cycle, then IDLE.
- solved holds its previous value until the scan that updates it completes.
- init_req, move_valid and move_dir are ignored outside IDLE.

## Timing
- **Reset values:**
  - Outputs: move_ready 0, done 0, illegal 0, solved 0, blank_pos 15, move_count 0, mem_addr 0, mem_wdata 0, mem_we 0.
  - Internal: state BOOT, idx 0.
- **Reset asserted mid-operation (any state):** all outputs and registers return to their reset values immediately. The board memory clears itself. A full INIT runs after release.
- **After reset release** (cycle 0 = first cycle in BOOT):
  - INIT occupies cycles 1..16.
  - done is high in cycle 17.
  - move_ready is high from cycle 18.
- **Legal move** (cycle 0 = first cycle after the accept edge):
  - RD in cycle 0, WR_B in 1, WR_N in 2.
  - SCAN in cycles 3..18.
  - done is high in cycle 19, with solved, blank_pos and move_count valid.
  - move_ready returns high in cycle 20.
- **Illegal move:** illegal is high in cycle 0 and move_ready returns high in cycle 1.
- **init_req from IDLE:** INIT in cycles 0..15, done in cycle 16.
- move_ready is low in every non-IDLE state. Back-to-back commands are therefore spaced by at least 21 cycles for a legal move and 2 cycles for an illegal one.

## Test plan
- **Reset release:** mem writes to addresses 0..15 carry data 1..15, 0 in cycles 1..16. Then done is high in cycle 17, with solved = 1, blank_pos = 15, move_count = 0.
- **Move up from solved:**
  - Memory sequence: read address 11 returns 12; write address 15 = 12; write address 11 = 0.
  - done is high in cycle 19 with blank_pos = 11, move_count = 1, solved = 0.
- **Move down with blank 15:** illegal pulses for one cycle. No mem_we is asserted, and blank_pos = 15, move_count = 0 are unchanged.
- **Up then down:** the board returns to the solved layout, with solved = 1, move_count = 2, blank_pos = 15.
- **init_req and move_valid high together in IDLE:** INIT runs and the move is not accepted. Afterwards move_count = 0, and the next move is accepted normally.
- **CNT_W = 2, five alternating legal moves:** move_count saturates at 3. Asserting rst_n = 0 during SCAN clears all outputs at once, and a new INIT runs after release.

Source files
------------

// File: rtl/board_ctrl.sv
// rtl/board_ctrl.sv - move sequencer for the 16-cell 4-bit sliding-puzzle board memory
module board_ctrl #(
  parameter int CNT_W = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             init_req,
  input  logic             move_valid,
  input  logic [1:0]       move_dir,
  output logic             move_ready,
  output logic             done,
  output logic             illegal,
  output logic             solved,
  output logic [3:0]       blank_pos,
  output logic [CNT_W-1:0] move_count,
  output logic [3:0]       mem_addr,
  output logic [3:0]       mem_wdata,
  output logic             mem_we,
  input  logic [3:0]       mem_rdata
);

  typedef enum logic [3:0] {BOOT, INIT, IDLE, ILL, RD, WR_B, WR_N, SCAN, DONE} state_t;

  state_t     state, state_nx;
  logic [3:0] idx;
  logic [3:0] nbr;
  logic [3:0] tile;
  logic       mism;
  logic       legal;
  logic [3:0] nbr_nx;
  logic [3:0] solved_val;
  logic       cell_bad;

  // Solved layout is idx+1 with 15 wrapping to 0, which 4-bit addition does for free.
  assign solved_val = idx + 4'd1;
  assign cell_bad   = (mem_rdata != solved_val);

  assign move_ready = (state == IDLE) && !init_req;
  assign done       = (state == DONE);
  assign illegal    = (state == ILL);

  always_comb begin
    legal  = 1'b0;
    nbr_nx = blank_pos;
    case (move_dir)
      2'b00: begin legal = (blank_pos[3:2] != 2'd0); nbr_nx = blank_pos - 4'd4; end
      2'b01: begin legal = (blank_pos[3:2] != 2'd3); nbr_nx = blank_pos + 4'd4; end
      2'b10: begin legal = (blank_pos[1:0] != 2'd0); nbr_nx = blank_pos - 4'd1; end
      default: begin legal = (blank_pos[1:0] != 2'd3); nbr_nx = blank_pos + 4'd1; end
    endcase
  end

  always_comb begin
    state_nx  = state;
    mem_addr  = 4'd0;
    mem_wdata = 4'd0;
    mem_we    = 1'b0;
    case (state)
      BOOT: state_nx = INIT;
      INIT: begin
        mem_addr  = idx;
        mem_wdata = solved_val;
        mem_we    = 1'b1;
        if (idx == 4'd15) state_nx = DONE;
      end
      IDLE: begin
        if (init_req)        state_nx = INIT;
        else if (move_valid) state_nx = legal ? RD : ILL;
      end
      ILL:  state_nx = IDLE;
      RD: begin
        mem_addr = nbr;
        state_nx = WR_B;
      end
      WR_B: begin
        mem_addr  = blank_pos;
        mem_wdata = tile;
        mem_we    = 1'b1;
        state_nx  = WR_N;
      end
      WR_N: begin
        mem_addr = nbr;
        mem_we   = 1'b1;
        state_nx = SCAN;
      end
      SCAN: begin
        mem_addr = idx;
        if (idx == 4'd15) state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= BOOT;
      idx        <= 4'd0;
      nbr        <= 4'd0;
      tile       <= 4'd0;
      mism       <= 1'b0;
      blank_pos  <= 4'd15;
      move_count <= '0;
      solved     <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        INIT: begin
          idx <= idx + 4'd1;
          if (idx == 4'd15) begin
            blank_pos  <= 4'd15;
            move_count <= '0;
            solved     <= 1'b1;
          end
        end
        IDLE: begin
          idx <= 4'd0;
          if (!init_req && move_valid && legal) nbr <= nbr_nx;
        end
        RD:   tile <= mem_rdata;
        WR_N: begin
          blank_pos <= nbr;
          if (move_count != '1) move_count <= move_count + 1'b1;
          mism <= 1'b0;
          idx  <= 4'd0;
        end
        SCAN: begin
          idx  <= idx + 4'd1;
          mism <= mism | cell_bad;
          if (idx == 4'd15) solved <= !(mism | cell_bad);
        end
        default: idx <= 4'd0;
      endcase
    end
  end

endmodule
